// File: rtl/zifi_uart_ctrl.sv
// Buffered ZX-Uno register-bus front end for a byte-level UART core.
// Provides TX/RX FIFOs, the txbegin/txbusy handshake, RX capture with overrun and RTS flow control.
module zifi_uart_ctrl #(
  parameter logic [7:0] UARTDATA   = 8'hC6,
  parameter logic [7:0] UARTSTAT   = 8'hC7,
  parameter int         TX_AW      = 4,
  parameter int         RX_AW      = 4,
  parameter int         RTS_MARGIN = 4
) (
  input  logic       clk_bus,
  input  logic       rst_n,
  input  logic [7:0] zxuno_addr,
  input  logic       zxuno_regrd,
  input  logic       zxuno_regwr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       oe_n,
  output logic [7:0] core_txdata,
  output logic       core_txbegin,
  input  logic       core_txbusy,
  input  logic [7:0] core_rxdata,
  input  logic       core_rxrecv,
  output logic       core_rxack,
  output logic       uart_rts_n
);

  localparam int TX_D = 1 << TX_AW;
  localparam int RX_D = 1 << RX_AW;
  localparam logic [TX_AW:0]   TX_DEPTH = (TX_AW+1)'(TX_D);
  localparam logic [RX_AW:0]   RX_DEPTH = (RX_AW+1)'(RX_D);
  localparam logic [RX_AW:0]   MARGIN   = (RX_AW+1)'(RTS_MARGIN);
  localparam logic [TX_AW-1:0] TX_P1    = 1;
  localparam logic [RX_AW-1:0] RX_P1    = 1;
  localparam logic [TX_AW:0]   TX_C1    = 1;
  localparam logic [RX_AW:0]   RX_C1    = 1;

  typedef enum logic [1:0] {IDLE, START, BUSY} state_t;
  state_t state, state_nx;

  logic       regwr_q, regrd_q, rxrecv_q;
  logic [7:0] rd_addr_q;
  logic       wr_rise, rd_fall, rx_rise;
  logic       wr_data, wr_stat, rd_data_end, rd_stat_end;
  logic       tx_load, overrun;

  logic [7:0]       tx_mem [TX_D];
  logic [TX_AW-1:0] tx_wp, tx_rp;
  logic [TX_AW:0]   tx_cnt;
  logic             tx_empty, tx_full, tx_push, tx_flush, tx_idle;

  logic [7:0]       rx_mem [RX_D];
  logic [RX_AW-1:0] rx_wp, rx_rp;
  logic [RX_AW:0]   rx_cnt, rx_free;
  logic             rx_empty, rx_full, rx_push, rx_pop, rx_flush;

  logic       sel_data, sel_stat;
  logic [7:0] stat;

  // Strobe edge detection; the read address is held so the access completes on the falling edge
  always_ff @(posedge clk_bus or negedge rst_n) begin
    if (!rst_n) begin
      regwr_q   <= 1'b0;
      regrd_q   <= 1'b0;
      rxrecv_q  <= 1'b0;
      rd_addr_q <= 8'h00;
    end else begin
      regwr_q  <= zxuno_regwr;
      regrd_q  <= zxuno_regrd;
      rxrecv_q <= core_rxrecv;
      if (zxuno_regrd) rd_addr_q <= zxuno_addr;
    end
  end

  assign wr_rise     = zxuno_regwr & ~regwr_q;
  assign rd_fall     = ~zxuno_regrd & regrd_q;
  assign rx_rise     = core_rxrecv & ~rxrecv_q;
  assign wr_data     = wr_rise & (zxuno_addr == UARTDATA);
  assign wr_stat     = wr_rise & (zxuno_addr == UARTSTAT);
  assign rd_data_end = rd_fall & (rd_addr_q == UARTDATA);
  assign rd_stat_end = rd_fall & (rd_addr_q == UARTSTAT);

  assign tx_empty = (tx_cnt == '0);
  assign tx_full  = (tx_cnt == TX_DEPTH);
  assign tx_push  = wr_data & ~tx_full;
  assign tx_flush = wr_stat & din[0];
  assign tx_idle  = tx_empty & (state == IDLE) & ~core_txbusy;

  assign rx_empty = (rx_cnt == '0);
  assign rx_full  = (rx_cnt == RX_DEPTH);
  assign rx_push  = rx_rise & ~rx_full;
  assign rx_pop   = rd_data_end & ~rx_empty;
  assign rx_flush = wr_stat & din[1];
  assign rx_free  = RX_DEPTH - rx_cnt;

  // FIFO storage carries no reset; occupancy is tracked by the pointers and counts
  always_ff @(posedge clk_bus) begin
    if (tx_push) tx_mem[tx_wp] <= din;
    if (rx_push) rx_mem[rx_wp] <= core_rxdata;
  end

  always_ff @(posedge clk_bus or negedge rst_n) begin
    if (!rst_n) begin
      tx_wp  <= '0;
      tx_rp  <= '0;
      tx_cnt <= '0;
    end else if (tx_flush) begin
      tx_wp  <= '0;
      tx_rp  <= '0;
      tx_cnt <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + TX_P1;
      if (tx_load) tx_rp <= tx_rp + TX_P1;
      case ({tx_push, tx_load})
        2'b10:   tx_cnt <= tx_cnt + TX_C1;
        2'b01:   tx_cnt <= tx_cnt - TX_C1;
        default: tx_cnt <= tx_cnt;
      endcase
    end
  end

  always_ff @(posedge clk_bus or negedge rst_n) begin
    if (!rst_n) begin
      rx_wp  <= '0;
      rx_rp  <= '0;
      rx_cnt <= '0;
    end else if (rx_flush) begin
      rx_wp  <= '0;
      rx_rp  <= '0;
      rx_cnt <= '0;
    end else begin
      if (rx_push) rx_wp <= rx_wp + RX_P1;
      if (rx_pop)  rx_rp <= rx_rp + RX_P1;
      case ({rx_push, rx_pop})
        2'b10:   rx_cnt <= rx_cnt + RX_C1;
        2'b01:   rx_cnt <= rx_cnt - RX_C1;
        default: rx_cnt <= rx_cnt;
      endcase
    end
  end

  // A byte arriving into a full FIFO takes precedence over a same-cycle overrun clear
  always_ff @(posedge clk_bus or negedge rst_n) begin
    if (!rst_n) begin
      overrun    <= 1'b0;
      core_rxack <= 1'b0;
      uart_rts_n <= 1'b0;
    end else begin
      if (rx_rise & rx_full)           overrun <= 1'b1;
      else if (rx_flush | rd_stat_end) overrun <= 1'b0;
      core_rxack <= rx_rise;
      uart_rts_n <= (rx_free < MARGIN);
    end
  end

  always_ff @(posedge clk_bus or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      core_txdata <= 8'h00;
    end else begin
      state <= state_nx;
      if (tx_load) core_txdata <= tx_mem[tx_rp];
    end
  end

  always_comb begin
    state_nx     = state;
    tx_load      = 1'b0;
    core_txbegin = 1'b0;
    case (state)
      IDLE: if (!tx_empty && !core_txbusy) begin
        tx_load  = 1'b1;
        state_nx = START;
      end
      START: begin
        core_txbegin = 1'b1;
        if (core_txbusy) state_nx = BUSY;
      end
      BUSY:    if (!core_txbusy) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign sel_data = zxuno_regrd & (zxuno_addr == UARTDATA);
  assign sel_stat = zxuno_regrd & (zxuno_addr == UARTSTAT);
  assign stat     = {~rx_empty, tx_full, ~tx_idle, overrun, 4'b0000};
  assign oe_n     = ~(sel_data | sel_stat);
  assign dout     = sel_data ? (rx_empty ? 8'h00 : rx_mem[rx_rp]) :
                    sel_stat ? stat : 8'hzz;

endmodule
